// File: rtl/code_match_game.sv
// code_match_game: two-player code-setting / code-guessing game.
// Each round the setter enters a CODE_LEN-symbol code and the guesser enters a
// guess of the same length. The guess is scored one position per cycle. The
// round's points are then added to the saturating player scores. Roles swap on
// odd rounds, and the game ends after ROUNDS rounds.
module code_match_game #(
    parameter int unsigned SYM_W    = 3,
    parameter int unsigned CODE_LEN = 4,
    parameter int unsigned ROUNDS   = 2,
    parameter int unsigned SCORE_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               enter1,
    input  logic               enter2,
    input  logic [SYM_W-1:0]   dataIn,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [7:0]         round_idx,
    output logic               expect1,
    output logic               expect2,
    output logic               busy,
    output logic               done
);

    localparam int unsigned IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int unsigned PTS_W = SCORE_W + 1;

    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(CODE_LEN - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [PTS_W-1:0]   PTS_MAX   = '1;

    localparam logic [2:0] StIdle      = 3'd0;
    localparam logic [2:0] StLoadCode  = 3'd1;
    localparam logic [2:0] StLoadGuess = 3'd2;
    localparam logic [2:0] StCalc      = 3'd3;
    localparam logic [2:0] StAcc       = 3'd4;
    localparam logic [2:0] StDone      = 3'd5;

    logic [2:0]                         state_q, state_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic [7:0]                         round_q, round_d;
    logic [SCORE_W-1:0]                 score1_q, score1_d;
    logic [SCORE_W-1:0]                 score2_q, score2_d;
    logic [CODE_LEN-1:0][SYM_W-1:0]     code_q, code_d;
    logic [CODE_LEN-1:0][SYM_W-1:0]     guess_q, guess_d;
    logic [CODE_LEN-1:0]                ex_q, ex_d;
    logic [CODE_LEN-1:0]                used_q, used_d;
    logic [PTS_W-1:0]                   pts1_q, pts1_d;
    logic [PTS_W-1:0]                   pts2_q, pts2_d;

    logic                               p1_setter;
    logic                               setter_strobe;
    logic                               guesser_strobe;
    logic [CODE_LEN-1:0][SYM_W-1:0]     guess_full;
    logic [CODE_LEN-1:0]                ex_new;
    logic                               match_found;
    logic [IDX_W-1:0]                   match_j;
    logic [1:0]                         set_inc;
    logic [1:0]                         gss_inc;
    logic [1:0]                         p1_inc;
    logic [1:0]                         p2_inc;
    logic [CODE_LEN-1:0]                used_upd;
    logic                               last_round;

    // Adds a small increment to a round-points counter, clamping at all-ones.
    function automatic logic [PTS_W-1:0] add_pts(input logic [PTS_W-1:0] p,
                                                 input logic [1:0] inc);
        logic [PTS_W:0] sum;
        sum = {1'b0, p} + (PTS_W + 1)'(inc);
        if (sum[PTS_W]) begin
            return PTS_MAX;
        end
        return sum[PTS_W-1:0];
    endfunction

    // Adds round points to a cumulative score, saturating at the maximum.
    function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] s,
                                                     input logic [PTS_W-1:0] p);
        logic [SCORE_W+1:0] sum;
        sum = {2'b00, s} + {1'b0, p};
        if (sum > {2'b00, SCORE_MAX}) begin
            return SCORE_MAX;
        end
        return sum[SCORE_W-1:0];
    endfunction

    // Role decode: player 1 sets the code on even rounds, guesses on odd ones.
    always_comb begin
        p1_setter      = ~round_q[0];
        setter_strobe  = p1_setter ? enter1 : enter2;
        guesser_strobe = p1_setter ? enter2 : enter1;
        last_round     = ({1'b0, round_q} + 9'd1) == 9'(ROUNDS);
    end

    // Exact-match flags for the complete guess, including the symbol arriving now.
    always_comb begin
        guess_full           = guess_q;
        guess_full[LAST_IDX] = dataIn;
        for (int i = 0; i < CODE_LEN; i++) begin
            ex_new[i] = (guess_full[i] == code_q[i]);
        end
    end

    // Lowest unconsumed code position matching the guess symbol under scoring.
    always_comb begin
        match_found = 1'b0;
        match_j     = '0;
        for (int j = 0; j < CODE_LEN; j++) begin
            if (!match_found && !used_q[j] && (code_q[j] == guess_q[idx_q])) begin
                match_found = 1'b1;
                match_j     = IDX_W'(j);
            end
        end
    end

    // Points awarded for the current guess position and the consumption update.
    always_comb begin
        set_inc  = 2'd0;
        gss_inc  = 2'd0;
        used_upd = used_q;
        if (ex_q[idx_q]) begin
            gss_inc = 2'd2;
        end else if (match_found) begin
            set_inc           = 2'd1;
            gss_inc           = 2'd1;
            used_upd[match_j] = 1'b1;
        end else begin
            set_inc = 2'd2;
        end
        p1_inc = p1_setter ? set_inc : gss_inc;
        p2_inc = p1_setter ? gss_inc : set_inc;
    end

    // Game FSM next-state and datapath updates.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        round_d  = round_q;
        score1_d = score1_q;
        score2_d = score2_q;
        code_d   = code_q;
        guess_d  = guess_q;
        ex_d     = ex_q;
        used_d   = used_q;
        pts1_d   = pts1_q;
        pts2_d   = pts2_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    score1_d = '0;
                    score2_d = '0;
                    round_d  = '0;
                    idx_d    = '0;
                    state_d  = StLoadCode;
                end
            end

            StLoadCode: begin
                if (setter_strobe) begin
                    code_d[idx_q] = dataIn;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = StLoadGuess;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            StLoadGuess: begin
                if (guesser_strobe) begin
                    guess_d[idx_q] = dataIn;
                    if (idx_q == LAST_IDX) begin
                        // Exact positions are pre-consumed so the partial scan skips them.
                        ex_d    = ex_new;
                        used_d  = ex_new;
                        pts1_d  = '0;
                        pts2_d  = '0;
                        idx_d   = '0;
                        state_d = StCalc;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            StCalc: begin
                used_d = used_upd;
                pts1_d = add_pts(pts1_q, p1_inc);
                pts2_d = add_pts(pts2_q, p2_inc);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = StAcc;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            StAcc: begin
                score1_d = sat_score(score1_q, pts1_q);
                score2_d = sat_score(score2_q, pts2_q);
                round_d  = round_q + 8'd1;
                state_d  = last_round ? StDone : StLoadCode;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            round_q  <= '0;
            score1_q <= '0;
            score2_q <= '0;
            code_q   <= '0;
            guess_q  <= '0;
            ex_q     <= '0;
            used_q   <= '0;
            pts1_q   <= '0;
            pts2_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            round_q  <= round_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            code_q   <= code_d;
            guess_q  <= guess_d;
            ex_q     <= ex_d;
            used_q   <= used_d;
            pts1_q   <= pts1_d;
            pts2_q   <= pts2_d;
        end
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        score1    = score1_q;
        score2    = score2_q;
        round_idx = round_q;
        expect1   = ((state_q == StLoadCode) && p1_setter) ||
                    ((state_q == StLoadGuess) && !p1_setter);
        expect2   = ((state_q == StLoadCode) && !p1_setter) ||
                    ((state_q == StLoadGuess) && p1_setter);
        busy      = (state_q == StCalc) || (state_q == StAcc);
        done      = (state_q == StDone);
    end

endmodule

// File: tb/tb_code_match_game.sv
// Bench for code_match_game: a default instance and a SCORE_W=3 instance share
// all stimulus. Expected scores are pushed when a guess completes and are popped
// when busy falls after the score update.
module tb_code_match_game;

    localparam int CL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       enter1 = 1'b0;
    logic       enter2 = 1'b0;
    logic [2:0] data_in = '0;

    logic [7:0] score1, score2, round_idx;
    logic       expect1, expect2, busy, done;
    logic [2:0] score1_s, score2_s;
    logic [7:0] round_idx_s;
    logic       expect1_s, expect2_s, busy_s, done_s;

    typedef struct {
        int s1;
        int s2;
        int s1s;
        int s2s;
        int rnd;
        int dn;
        int cyc;
    } exp_t;

    exp_t sb_q[$];

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int busy_cnt = 0;

    int m_s1, m_s2, m_s1s, m_s2s, m_round;

    code_match_game dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .enter1    (enter1),
        .enter2    (enter2),
        .dataIn    (data_in),
        .score1    (score1),
        .score2    (score2),
        .round_idx (round_idx),
        .expect1   (expect1),
        .expect2   (expect2),
        .busy      (busy),
        .done      (done)
    );

    code_match_game #(.SCORE_W(3)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .enter1    (enter1),
        .enter2    (enter2),
        .dataIn    (data_in),
        .score1    (score1_s),
        .score2    (score2_s),
        .round_idx (round_idx_s),
        .expect1   (expect1_s),
        .expect2   (expect2_s),
        .busy      (busy_s),
        .done      (done_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Reference scoring: exact +2 guesser, partial +1 each, miss +2 setter.
    function automatic void model(input logic [15:0] code, input logic [15:0] guess,
                                  output int set_p, output int gss_p);
        int  c[CL];
        int  g[CL];
        bit  used[CL];
        bit  found;
        set_p = 0;
        gss_p = 0;
        for (int i = 0; i < CL; i++) begin
            c[i] = int'(code[15-4*i -: 4]);
            g[i] = int'(guess[15-4*i -: 4]);
            used[i] = (c[i] == g[i]);
        end
        for (int i = 0; i < CL; i++) begin
            if (c[i] == g[i]) begin
                gss_p += 2;
            end else begin
                found = 1'b0;
                for (int j = 0; j < CL; j++) begin
                    if (!found && !used[j] && c[j] == g[i]) begin
                        used[j] = 1'b1;
                        found = 1'b1;
                    end
                end
                if (found) begin
                    set_p += 1;
                    gss_p += 1;
                end else begin
                    set_p += 2;
                end
            end
        end
    endfunction

    // One symbol strobe; called and returns #1 after a rising edge.
    task automatic drive_sym(input bit p1, input bit both, input logic [2:0] sym);
        enter1  = p1 | both;
        enter2  = ~p1 | both;
        data_in = sym;
        @(posedge clk);
        #1;
        enter1 = 1'b0;
        enter2 = 1'b0;
    endtask

    task automatic start_game();
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        m_s1    = 0;
        m_s2    = 0;
        m_s1s   = 0;
        m_s2s   = 0;
        m_round = 0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 40; t++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        check_eq("drain", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic play_round(input logic [15:0] code, input logic [15:0] guess,
                              input bit both_first);
        bit   p1_set;
        int   set_p, gss_p;
        exp_t e;
        p1_set = (m_round % 2 == 0);
        for (int i = 0; i < CL; i++) begin
            drive_sym(p1_set, both_first && i == 0, code[14-4*i -: 3]);
        end
        for (int i = 0; i < CL; i++) begin
            drive_sym(!p1_set, 1'b0, guess[14-4*i -: 3]);
        end
        model(code, guess, set_p, gss_p);
        if (p1_set) begin
            m_s1 += set_p; m_s2 += gss_p; m_s1s += set_p; m_s2s += gss_p;
        end else begin
            m_s1 += gss_p; m_s2 += set_p; m_s1s += gss_p; m_s2s += set_p;
        end
        m_s1  = sat(m_s1, 255);
        m_s2  = sat(m_s2, 255);
        m_s1s = sat(m_s1s, 7);
        m_s2s = sat(m_s2s, 7);
        m_round++;
        e.s1  = m_s1;
        e.s2  = m_s2;
        e.s1s = m_s1s;
        e.s2s = m_s2s;
        e.rnd = m_round;
        e.dn  = (m_round == 2) ? 1 : 0;
        e.cyc = cyc + CL + 1;
        sb_q.push_back(e);
        wait_drain();
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_score1"}, int'(score1), 0);
        check_eq({tag, "_score2"}, int'(score2), 0);
        check_eq({tag, "_round"}, int'(round_idx), 0);
        check_eq({tag, "_expect1"}, int'(expect1), 0);
        check_eq({tag, "_expect2"}, int'(expect2), 0);
        check_eq({tag, "_busy"}, int'(busy), 0);
        check_eq({tag, "_done"}, int'(done), 0);
        check_eq({tag, "_score1_s"}, int'(score1_s), 0);
        check_eq({tag, "_score2_s"}, int'(score2_s), 0);
    endtask

    // Scoreboard consumer: compares when busy drops after the score update.
    always @(negedge clk) begin
        exp_t e;
        if (busy) begin
            busy_cnt++;
        end else if (busy_cnt != 0) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_empty", sb_q.size(), 1);
            end else begin
                e = sb_q.pop_front();
                check_eq("score1", int'(score1), e.s1);
                check_eq("score2", int'(score2), e.s2);
                check_eq("round_idx", int'(round_idx), e.rnd);
                check_eq("done", int'(done), e.dn);
                check_eq("score1_sat", int'(score1_s), e.s1s);
                check_eq("score2_sat", int'(score2_s), e.s2s);
                check_eq("done_sat", int'(done_s), e.dn);
                check_eq("latency", cyc, e.cyc);
                check_eq("busy_cycles", busy_cnt, CL + 1);
            end
            busy_cnt = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b1;

        // Game A: exact round, then role swap with ignored player-1 strobes.
        start_game();
        check_eq("expect1_code", int'(expect1), 1);
        play_round(16'h1234, 16'h1234, 1'b0);
        check_eq("r1_expect2", int'(expect2), 1);
        check_eq("r1_expect1", int'(expect1), 0);
        drive_sym(1'b1, 1'b0, 3'd5);
        drive_sym(1'b1, 1'b0, 3'd6);
        check_eq("r1_round_hold", int'(round_idx), 1);
        check_eq("r1_expect2_hold", int'(expect2), 1);
        play_round(16'h0000, 16'h1111, 1'b1);

        // Game B: all-partial round, then exact-consumes-code round.
        start_game();
        play_round(16'h1234, 16'h4321, 1'b0);
        play_round(16'h5111, 16'h5555, 1'b0);

        // Game C: one partial with duplicates, then all-miss.
        start_game();
        play_round(16'h1223, 16'h2777, 1'b0);
        play_round(16'h0000, 16'h1111, 1'b0);

        // Game D: all-miss both rounds drives the narrow instance to saturation.
        start_game();
        play_round(16'h0000, 16'h7777, 1'b0);
        play_round(16'h0000, 16'h7777, 1'b0);

        // Reset mid-guess, then a fresh game must score from scratch.
        start_game();
        for (int i = 0; i < CL; i++) drive_sym(1'b1, 1'b0, 3'(i + 1));
        drive_sym(1'b0, 1'b0, 3'd1);
        drive_sym(1'b0, 1'b0, 3'd2);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_idle("midreset");
        rst = 1'b1;
        start_game();
        play_round(16'h1234, 16'h1234, 1'b0);
        play_round(16'h0000, 16'h1111, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
